pc_fetch_unit: RTL and testbench

- Parametrised successor to the single-cycle PC path, built for the pipelined core.
- Holds the fetch PC and issues fetch requests to instruction memory with a valid/ready handshake.
- Honours decode stalls and accepts redirects from execute: branch, JALR, trap and absolute/return.
- Detects misaligned redirect targets, vectors them to the trap handler, and reports the faulting address.

---
 rtl/pc_fetch_if.sv | 40 ++++
 rtl/pc_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_if
// Purpose : bundles the fetch-side signals of pc_fetch_unit: the instruction
//           memory request handshake, the decode stall, the execute redirect
//           bus and the kill/misalign reporting back to the pipeline.
// Modports:
//   master - the fetch unit: drives fetch_valid, pc_out, pc_plus4,
//            fetch_kill, misalign and bad_addr; samples everything else.
//   slave  - the surrounding core / imem: the mirror image of master.
// Signals : stall, fetch_ready, fetch_valid, pc_out[WIDTH], pc_plus4[WIDTH],
//           redirect_valid, redirect_mode[2], ex_pc[WIDTH], rs1[WIDTH],
//           imm[WIDTH], fetch_kill, misalign, bad_addr[WIDTH].
// -----------------------------------------------------------------------------
interface pc_fetch_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             fetch_ready;
  logic             fetch_valid;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus4;
  logic             redirect_valid;
  logic [1:0]       redirect_mode;
  logic [WIDTH-1:0] ex_pc;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] imm;
  logic             fetch_kill;
  logic             misalign;
  logic [WIDTH-1:0] bad_addr;

  modport master (
    input  stall, fetch_ready, redirect_valid, redirect_mode, ex_pc, rs1, imm,
    output fetch_valid, pc_out, pc_plus4, fetch_kill, misalign, bad_addr
  );

  modport slave (
    output stall, fetch_ready, redirect_valid, redirect_mode, ex_pc, rs1, imm,
    input  fetch_valid, pc_out, pc_plus4, fetch_kill, misalign, bad_addr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Purpose : holds the fetch PC of the pipelined core and issues fetch requests
//           to instruction memory with a valid/ready handshake. Honours decode
//           stalls, takes redirects from execute (branch, JALR, trap, return),
//           traps misaligned redirect targets to TRAP_VECTOR and records the
//           faulting address.
// Ports   :
//   clk  - core clock, rising edge
//   rst  - asynchronous reset, active-low
//   bus  - pc_fetch_if.master (handshake, redirect bus, kill/misalign report)
//   perf_fetches[31:0], perf_redirects[31:0] - only with PC_PERF_EN
// Options : define PC_PERF_EN to add the fetch/redirect performance counters.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
  parameter int               INC          = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PC_PERF_EN
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_redirects,
`endif
  pc_fetch_if.master  bus
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
  localparam logic [WIDTH-1:0] CLR_BIT0 = {{(WIDTH-1){1'b1}}, 1'b0};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             kill_q, kill_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] bad_addr_q, bad_addr_d;

  logic [WIDTH-1:0] target;
  logic             target_misaligned;
  logic             fetch_vld;
  logic             fetch_fire;

  // Redirect target; all sums are WIDTH bits with the carry dropped.
  always_comb begin
    target = rs1_sel();
    case (bus.redirect_mode)
      2'd0:    target = bus.ex_pc + bus.imm;
      2'd1:    target = (bus.rs1 + bus.imm) & CLR_BIT0;
      2'd2:    target = TRAP_VECTOR;
      default: target = bus.rs1;
    endcase
  end

  function automatic logic [WIDTH-1:0] rs1_sel();
    return bus.rs1;
  endfunction

  // TRAP_VECTOR is aligned by construction, so checking the low bits is safe
  // for every mode.
  assign target_misaligned = (target[1:0] != 2'b00);

  assign fetch_fire = fetch_vld & bus.fetch_ready;

  // Next-state / output logic. Redirect beats stall beats handshake.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = 1'b0;
    misalign_d = 1'b0;
    bad_addr_d = bad_addr_q;
    fetch_vld  = 1'b0;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     fetch_vld = ~bus.stall;
      default: state_d = BOOT;
    endcase

    if (bus.redirect_valid) begin
      kill_d = 1'b1;
      if (target_misaligned) begin
        pc_d       = TRAP_VECTOR;
        misalign_d = 1'b1;
        bad_addr_d = target;
      end else begin
        pc_d = target;
      end
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (fetch_fire) begin
      pc_d = pc_q + INC_W;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign bus.fetch_valid = fetch_vld;
  assign bus.pc_out      = pc_q;
  assign bus.pc_plus4    = pc_q + INC_W;
  assign bus.fetch_kill  = kill_q;
  assign bus.misalign    = misalign_q;
  assign bus.bad_addr    = bad_addr_q;

`ifdef PC_PERF_EN
  logic [31:0] perf_fetches_q;
  logic [31:0] perf_redirects_q;

  // Counters wrap naturally at 2^32 and ignore stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetches_q   <= 32'd0;
      perf_redirects_q <= 32'd0;
    end else begin
      if (fetch_fire)         perf_fetches_q   <= perf_fetches_q + 32'd1;
      if (bus.redirect_valid) perf_redirects_q <= perf_redirects_q + 32'd1;
    end
  end

  assign perf_fetches   = perf_fetches_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Table-driven bench for pc_fetch_unit. Each record holds one cycle's inputs
// and the outputs expected during that cycle; expected records are queued when
// the inputs are driven and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic clk;
  logic rst;

  pc_fetch_if #(.WIDTH(32)) bus ();

`ifdef PC_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_redirects;
`endif

  pc_fetch_unit #(
    .WIDTH       (32),
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100),
    .INC         (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef PC_PERF_EN
    .perf_fetches  (perf_fetches),
    .perf_redirects(perf_redirects),
`endif
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rdy;
    logic        rv;
    logic [1:0]  mode;
    logic [31:0] ex_pc;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic        ev;
    logic [31:0] epc;
    logic        ek;
    logic        em;
    logic [31:0] ebad;
  } vec_t;

  int   n_tests;
  int   n_fail;
  vec_t tbl [21];
  vec_t exp_q [$];

  function automatic vec_t mk(input logic stall, input logic rdy, input logic rv,
                              input logic [1:0] mode, input logic [31:0] ex_pc,
                              input logic [31:0] rs1, input logic [31:0] imm,
                              input logic ev, input logic [31:0] epc,
                              input logic ek, input logic em,
                              input logic [31:0] ebad);
    vec_t v;
    v.stall = stall; v.rdy = rdy; v.rv = rv; v.mode = mode;
    v.ex_pc = ex_pc; v.rs1 = rs1; v.imm = imm;
    v.ev = ev; v.epc = epc; v.ek = ek; v.em = em; v.ebad = ebad;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, compare its outputs, then step the
  // rising edge.
  task automatic apply_vec(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    bus.stall          = v.stall;
    bus.fetch_ready    = v.rdy;
    bus.redirect_valid = v.rv;
    bus.redirect_mode  = v.mode;
    bus.ex_pc          = v.ex_pc;
    bus.rs1            = v.rs1;
    bus.imm            = v.imm;
    exp_q.push_back(v);
    #2;
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, e.ev});
      check({tag, " pc_out"},      bus.pc_out,   e.epc);
      check({tag, " pc_plus4"},    bus.pc_plus4, e.epc + 32'd4);
      check({tag, " fetch_kill"},  {31'd0, bus.fetch_kill}, {31'd0, e.ek});
      check({tag, " misalign"},    {31'd0, bus.misalign},   {31'd0, e.em});
      check({tag, " bad_addr"},    bus.bad_addr, e.ebad);
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //           stall rdy rv mode ex_pc          rs1            imm            ev epc            ek em bad
    tbl[0]  = mk(0, 1, 0, 2'd0, 32'h0,         32'h0,         32'h0,         0, 32'h0,         0, 0, 32'h0);
    tbl[1]  = mk(0, 1, 0, 2'd0, 32'h0,         32'h0,         32'h0,         1, 32'h0,         0, 0, 32'h0);
    tbl[2]  = mk(0, 1, 0, 2'd0, 32'h0,         32'h0,         32'h0,         1, 32'h4,         0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 0, 2'd0, 32'h0,         32'h0,         32'h0,         1, 32'h8,         0, 0, 32'h0);
    tbl[4]  = mk(0, 0, 0, 2'd0, 32'h0,         32'h0,         32'h0,         1, 32'h8,         0, 0, 32'h0);
    tbl[5]  = mk(0, 0, 0, 2'd0, 32'h0,         32'h0,         32'h0,         1, 32'h8,         0, 0, 32'h0);
    tbl[6]  = mk(0, 1, 0, 2'd0, 32'h0,         32'h0,         32'h0,         1, 32'h8,         0, 0, 32'h0);
    tbl[7]  = mk(0, 0, 0, 2'd0, 32'h0,         32'h0,         32'h0,         1, 32'hC,         0, 0, 32'h0);
    // Redirect concurrent with stall; pc then held under stall.
    tbl[8]  = mk(1, 1, 1, 2'd0, 32'h20,        32'h0,         32'hFFFF_FFF0, 0, 32'hC,         0, 0, 32'h0);
    tbl[9]  = mk(1, 1, 0, 2'd0, 32'h0,         32'h0,         32'h0,         0, 32'h10,        1, 0, 32'h0);
    tbl[10] = mk(1, 1, 0, 2'd0, 32'h0,         32'h0,         32'h0,         0, 32'h10,        0, 0, 32'h0);
    // JALR clears bit0, then a misaligned return traps.
    tbl[11] = mk(0, 0, 1, 2'd1, 32'h0,         32'h101,       32'h4,         1, 32'h10,        0, 0, 32'h0);
    tbl[12] = mk(0, 1, 1, 2'd3, 32'h0,         32'h102,       32'h0,         1, 32'h104,       1, 0, 32'h0);
    tbl[13] = mk(0, 1, 0, 2'd0, 32'h0,         32'h0,         32'h0,         1, 32'h100,       1, 1, 32'h102);
    tbl[14] = mk(0, 0, 0, 2'd0, 32'h0,         32'h0,         32'h0,         1, 32'h104,       0, 0, 32'h102);
    // Trap mode, then a redirect to the top word and a wrapping fetch.
    tbl[15] = mk(0, 0, 1, 2'd2, 32'h0,         32'h0,         32'h0,         1, 32'h104,       0, 0, 32'h102);
    tbl[16] = mk(1, 0, 1, 2'd0, 32'hFFFF_FFF0, 32'h0,         32'hC,         0, 32'h100,       1, 0, 32'h102);
    tbl[17] = mk(0, 1, 0, 2'd0, 32'h0,         32'h0,         32'h0,         1, 32'hFFFF_FFFC, 1, 0, 32'h102);
    // Misaligned branch target records its own bad address.
    tbl[18] = mk(0, 0, 1, 2'd0, 32'h10,        32'h0,         32'h1,         1, 32'h0,         0, 0, 32'h102);
    tbl[19] = mk(1, 1, 0, 2'd0, 32'h0,         32'h0,         32'h0,         0, 32'h100,       1, 1, 32'h11);
    tbl[20] = mk(1, 1, 0, 2'd0, 32'h0,         32'h0,         32'h0,         0, 32'h100,       0, 0, 32'h11);

    rst                = 1'b0;
    bus.stall          = 1'b0;
    bus.fetch_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_mode  = 2'd0;
    bus.ex_pc          = '0;
    bus.rs1            = '0;
    bus.imm            = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset pc_out",      bus.pc_out, 32'h0);
    check("reset fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    check("reset fetch_kill",  {31'd0, bus.fetch_kill},  32'd0);
    check("reset misalign",    {31'd0, bus.misalign},    32'd0);
    check("reset bad_addr",    bus.bad_addr, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    // The edge above already moved BOOT->RUN with rst high, so re-enter reset
    // to line up the table's BOOT row with the first edge after release.
    #1 rst = 1'b0;
    #1 rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted mid-stall, away from any clock edge.
    #3;
    bus.stall = 1'b1;
    rst       = 1'b0;
    #1;
    check("midrst pc_out",      bus.pc_out, 32'h0);
    check("midrst fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    check("midrst bad_addr",    bus.bad_addr, 32'h0);
    check("midrst fetch_kill",  {31'd0, bus.fetch_kill}, 32'd0);
    rst = 1'b1;

    // BOOT repeats, then five accepted fetches and two stalled redirects.
    apply_vec(mk(0, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0,   0, 0, 32'h0), "boot2");
    apply_vec(mk(0, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 1, 32'h0,   0, 0, 32'h0), "run0");
    apply_vec(mk(0, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 1, 32'h4,   0, 0, 32'h0), "run1");
    apply_vec(mk(0, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 1, 32'h8,   0, 0, 32'h0), "run2");
    apply_vec(mk(0, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 1, 32'hC,   0, 0, 32'h0), "run3");
    apply_vec(mk(0, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 1, 32'h10,  0, 0, 32'h0), "run4");
    apply_vec(mk(1, 1, 1, 2'd2, 32'h0, 32'h0, 32'h0, 0, 32'h14,  0, 0, 32'h0), "rd0");
    apply_vec(mk(1, 1, 1, 2'd2, 32'h0, 32'h0, 32'h0, 0, 32'h100, 1, 0, 32'h0), "rd1");
    apply_vec(mk(1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 32'h100, 1, 0, 32'h0), "hold0");
    apply_vec(mk(1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 32'h100, 0, 0, 32'h0), "hold1");

`ifdef PC_PERF_EN
    #1;
    check("perf_fetches",   perf_fetches,   32'd5);
    check("perf_redirects", perf_redirects, 32'd2);
`endif

    check("queue drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
